tl_mem_arbiter: RTL and testbench

- Shares one single-outstanding TileLink-to-memory bridge (reg-bus SRAM/ROM port) among NUM_REQ TileLink requesters.
- Round-robin grant on channel A, holds the grant until downstream accept, and routes the single D response back to the owning requester.
- Sits between core/DMA/debug TL masters and the TL-to-memory bridge in the sy_tl subsystem.
- Guarantees at most one transaction in flight downstream.

---
 rtl/tl_pkg.sv | 35 +++
 rtl/rr_arbiter.sv | 27 ++
 rtl/tl_mem_arbiter.sv | 179 +++++++++++++++++
 tb/tb_tl_mem_arbiter.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared TileLink channel payloads and arbiter definitions for the sy_tl subsystem.
package tl_pkg;

    localparam int TL_ARB_MAX_REQ = 8;

    localparam logic [2:0] TL_A_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_A_GET             = 3'd4;
    localparam logic [2:0] TL_D_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_D_ACCESS_ACK_DATA = 3'd1;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  param;
        logic [1:0]  size;
        logic [7:0]  source;
        logic [31:0] address;
        logic [3:0]  mask;
        logic [31:0] data;
        logic        corrupt;
    } A_chan_bits_t;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [1:0]  param;
        logic [1:0]  size;
        logic [7:0]  source;
        logic        sink;
        logic        denied;
        logic [31:0] data;
        logic        corrupt;
    } D_chan_bits_t;

    typedef enum logic [1:0] {IDLE, HOLD, WAIT_D, DRAIN} tl_arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first valid requester scanning upward from ptr, wrapping at N.
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          any_valid
);

    logic [IW-1:0] j;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        j         = '0;
        for (int i = 0; i < N; i++) begin
            j = IW'((int'(ptr) + i) % N);
            if (!any_valid && valid[j]) begin
                grant     = j;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tl_mem_arbiter.sv
// Round-robin share of one single-outstanding TL-to-memory bridge among NUM_REQ masters.
// Define TL_ARB_TIMEOUT_EN to add the WAIT_D watchdog with a denied response and DRAIN state.
module tl_mem_arbiter
    import tl_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_REQ-1:0]       req_A_valid_i,
    output logic [NUM_REQ-1:0]       req_A_ready_o,
    input  A_chan_bits_t             req_A_bits_i [NUM_REQ],
    output logic [NUM_REQ-1:0]       req_D_valid_o,
    input  logic [NUM_REQ-1:0]       req_D_ready_i,
    output D_chan_bits_t             req_D_bits_o [NUM_REQ],
    output logic                     mem_A_valid_o,
    input  logic                     mem_A_ready_i,
    output A_chan_bits_t             mem_A_bits_o,
    input  logic                     mem_D_valid_i,
    output logic                     mem_D_ready_o,
    input  D_chan_bits_t             mem_D_bits_i,
    output logic                     busy_o,
    output logic                     timeout_o
);

    localparam int IW = $clog2(NUM_REQ);

    tl_arb_state_e state;
    logic [IW-1:0] rr_ptr, owner, grant, sel, next_ptr;
    logic          any_valid, a_fire, d_fire;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .valid     (req_A_valid_i),
        .ptr       (rr_ptr),
        .grant     (grant),
        .any_valid (any_valid)
    );

    assign sel      = (state == IDLE) ? grant : owner;
    assign next_ptr = (owner == IW'(NUM_REQ - 1)) ? '0 : owner + IW'(1);
    assign a_fire   = mem_A_valid_o && mem_A_ready_i;
    assign d_fire   = req_D_valid_o[owner] && req_D_ready_i[owner];
    assign busy_o   = (state != IDLE);

`ifdef TL_ARB_TIMEOUT_EN
    logic [15:0]  cnt;
    logic [7:0]   src_q;
    logic         expired;
    D_chan_bits_t timeout_d;

    assign expired = (cnt >= 16'(TIMEOUT_CYCLES));

    always_comb begin
        timeout_d         = '0;
        timeout_d.opcode  = TL_D_ACCESS_ACK_DATA;
        timeout_d.source  = src_q;
        timeout_d.denied  = 1'b1;
        timeout_d.corrupt = 1'b1;
    end
`else
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        req_A_ready_o = '0;
        req_D_valid_o = '0;
        mem_A_valid_o = 1'b0;
        mem_A_bits_o  = req_A_bits_i[sel];
        mem_D_ready_o = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            req_D_bits_o[k] = mem_D_bits_i;
        end
        if (!rst_i) begin
            case (state)
                IDLE: begin
                    mem_A_valid_o        = any_valid;
                    req_A_ready_o[grant] = any_valid && mem_A_ready_i;
                end
                HOLD: begin
                    mem_A_valid_o        = req_A_valid_i[owner];
                    req_A_ready_o[owner] = mem_A_ready_i;
                end
                WAIT_D: begin
                    req_D_valid_o[owner] = mem_D_valid_i;
                    mem_D_ready_o        = req_D_ready_i[owner];
`ifdef TL_ARB_TIMEOUT_EN
                    // Bridge is presumed hung: answer locally, hold off the bridge.
                    if (expired) begin
                        req_D_valid_o[owner] = 1'b1;
                        mem_D_ready_o        = 1'b0;
                        for (int k = 0; k < NUM_REQ; k++) begin
                            req_D_bits_o[k] = timeout_d;
                        end
                    end
`endif
                end
`ifdef TL_ARB_TIMEOUT_EN
                DRAIN: mem_D_ready_o = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
`ifdef TL_ARB_TIMEOUT_EN
            cnt       <= '0;
            src_q     <= '0;
            timeout_o <= 1'b0;
`endif
        end else begin
`ifdef TL_ARB_TIMEOUT_EN
            timeout_o <= 1'b0;
`endif
            case (state)
                IDLE: if (any_valid) begin
                    owner <= grant;
                    state <= mem_A_ready_i ? WAIT_D : HOLD;
`ifdef TL_ARB_TIMEOUT_EN
                    cnt   <= '0;
                    src_q <= req_A_bits_i[grant].source;
`endif
                end
                HOLD: if (a_fire) begin
                    state <= WAIT_D;
`ifdef TL_ARB_TIMEOUT_EN
                    cnt   <= '0;
                    src_q <= req_A_bits_i[owner].source;
`endif
                end
                WAIT_D: begin
                    if (d_fire) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
`ifdef TL_ARB_TIMEOUT_EN
                    if (expired) begin
                        if (d_fire) begin
                            rr_ptr    <= rr_ptr;
                            state     <= DRAIN;
                            timeout_o <= 1'b1;
                            cnt       <= '0;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
`endif
                end
`ifdef TL_ARB_TIMEOUT_EN
                DRAIN: begin
                    if (mem_D_valid_i || expired) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    a_params: assert property (@(posedge clk_i)
        NUM_REQ >= 2 && NUM_REQ <= TL_ARB_MAX_REQ &&
        TIMEOUT_CYCLES > 0 && TIMEOUT_CYCLES < 65536);

    a_hold_valid: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == HOLD) |-> req_A_valid_i[owner]);

    a_no_stray_d: assert property (@(posedge clk_i) disable iff (rst_i)
        (state == IDLE || state == HOLD) |-> (req_D_valid_o == '0 && !mem_D_ready_o));

endmodule

// File: tb/tb_tl_mem_arbiter.sv
// Bench for tl_mem_arbiter: grant-table vectors plus a scoreboarded bridge model.
module tb_tl_mem_arbiter;
    import tl_pkg::*;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_i;
    logic [N-1:0] req_A_valid_i, req_A_ready_o, req_D_valid_o, req_D_ready_i;
    A_chan_bits_t req_A_bits_i [N];
    D_chan_bits_t req_D_bits_o [N];
    logic         mem_A_valid_o, mem_A_ready_i, mem_D_valid_i, mem_D_ready_o;
    A_chan_bits_t mem_A_bits_o;
    D_chan_bits_t mem_D_bits_i;
    logic         busy_o, timeout_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tl_mem_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(1024)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_A_valid_i (req_A_valid_i),
        .req_A_ready_o (req_A_ready_o),
        .req_A_bits_i  (req_A_bits_i),
        .req_D_valid_o (req_D_valid_o),
        .req_D_ready_i (req_D_ready_i),
        .req_D_bits_o  (req_D_bits_o),
        .mem_A_valid_o (mem_A_valid_o),
        .mem_A_ready_i (mem_A_ready_i),
        .mem_A_bits_o  (mem_A_bits_o),
        .mem_D_valid_i (mem_D_valid_i),
        .mem_D_ready_o (mem_D_ready_o),
        .mem_D_bits_i  (mem_D_bits_i),
        .busy_o        (busy_o),
        .timeout_o     (timeout_o)
    );

    typedef struct {
        int          owner;
        logic [7:0]  source;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic [N-1:0] valid;
        logic         rdy;
        logic         exp_mv;
        int           exp_grant;
        logic [N-1:0] exp_rdy;
    } vec_t;

    exp_t        sb[$];
    int          grants[$];
    int          left[N];
    bit          bridge_on;
    int          bridge_lat;
    int          outstanding;
    bit          pend;
    int          lat_cnt;
    logic [7:0]  pend_src;
    logic [31:0] pend_addr;
    vec_t        vt[7];

    function automatic A_chan_bits_t pay(int k);
        A_chan_bits_t a = '0;
        a.opcode  = TL_A_GET;
        a.size    = 2'd2;
        a.source  = 8'hA0 + 8'(k);
        a.address = 32'h8000_0000 + 32'(k * 16);
        a.mask    = 4'hF;
        return a;
    endfunction

    function automatic logic [31:0] mem_data(logic [31:0] addr);
        return 32'hDEAD_BEEF + (addr - 32'h8000_0010);
    endfunction

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic apply_valid();
        for (int k = 0; k < N; k++) req_A_valid_i[k] = (left[k] > 0);
    endtask

    function automatic bit work_left();
        for (int k = 0; k < N; k++) if (left[k] > 0) return 1'b1;
        return (outstanding != 0) || busy_o;
    endfunction

    task automatic tick();
        bit          a_fire, d_dn;
        int          k_a;
        logic [31:0] addr;
        logic [7:0]  src;
        exp_t        e;
        @(negedge clk);
        a_fire = mem_A_valid_o && mem_A_ready_i;
        d_dn   = mem_D_valid_i && mem_D_ready_o;
        k_a    = -1;
        addr   = mem_A_bits_o.address;
        src    = mem_A_bits_o.source;
        if (a_fire) begin
            for (int k = 0; k < N; k++) if (req_A_ready_o[k]) k_a = k;
            chk("a_overlap", 64'(outstanding), 0);
            chk("a_grant_onehot", 64'($onehot(req_A_ready_o)), 1);
            if (k_a >= 0) begin
                chk("a_source", src, pay(k_a).source);
                chk("a_addr", addr, pay(k_a).address);
                e.owner  = k_a;
                e.source = pay(k_a).source;
                e.data   = mem_data(pay(k_a).address);
                sb.push_back(e);
                grants.push_back(k_a);
            end
            outstanding = 1;
        end
        for (int k = 0; k < N; k++) begin
            if (req_D_valid_o[k] && req_D_ready_i[k]) begin
                chk("d_expected", 64'(sb.size() > 0), 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    chk("d_owner", 64'(k), 64'(e.owner));
                    chk("d_source", req_D_bits_o[k].source, e.source);
                    chk("d_data", req_D_bits_o[k].data, e.data);
                end
                outstanding = 0;
            end
        end
        @(posedge clk);
        #1;
        if (d_dn) begin
            mem_D_valid_i = 1'b0;
            pend = 1'b0;
        end
        if (a_fire) begin
            pend      = 1'b1;
            lat_cnt   = bridge_lat;
            pend_src  = src;
            pend_addr = addr;
            if (k_a >= 0 && left[k_a] > 0) left[k_a]--;
        end
        if (bridge_on && pend && !mem_D_valid_i) begin
            if (lat_cnt == 0) begin
                mem_D_bits_i        = '0;
                mem_D_bits_i.opcode = TL_D_ACCESS_ACK_DATA;
                mem_D_bits_i.size   = 2'd2;
                mem_D_bits_i.source = pend_src;
                mem_D_bits_i.data   = mem_data(pend_addr);
                mem_D_valid_i       = 1'b1;
            end else begin
                lat_cnt--;
            end
        end
        apply_valid();
    endtask

    task automatic wait_drain(string name, int budget);
        int n = 0;
        while (work_left() && n < budget) begin
            tick();
            n++;
        end
        chk(name, 64'(work_left()), 0);
    endtask

    task automatic check_order(string name, int exp[$]);
        chk({name, "_count"}, 64'(grants.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < grants.size(); i++)
            chk({name, "_grant"}, 64'(grants[i]), 64'(exp[i]));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        for (int k = 0; k < N; k++) left[k] = 0;
        apply_valid();
        mem_D_valid_i = 1'b0;
        mem_D_bits_i  = '0;
        pend          = 1'b0;
        outstanding   = 0;
        sb.delete();
        grants.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
    endtask

    initial begin
        int q[$];
        int n;
        vt[0] = '{3'b000, 1'b1, 1'b0, 0, 3'b000};
        vt[1] = '{3'b001, 1'b1, 1'b1, 0, 3'b001};
        vt[2] = '{3'b010, 1'b1, 1'b1, 1, 3'b010};
        vt[3] = '{3'b110, 1'b0, 1'b1, 1, 3'b000};
        vt[4] = '{3'b111, 1'b1, 1'b1, 0, 3'b001};
        vt[5] = '{3'b100, 1'b1, 1'b1, 2, 3'b100};
        vt[6] = '{3'b101, 1'b0, 1'b1, 0, 3'b000};

        for (int k = 0; k < N; k++) req_A_bits_i[k] = pay(k);
        req_D_ready_i = '1;
        mem_A_ready_i = 1'b1;
        bridge_on     = 1'b1;
        bridge_lat    = 0;
        do_reset();

        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_mem_a_valid", mem_A_valid_o, 0);
        chk("rst_req_a_ready", req_A_ready_o, 0);
        chk("rst_req_d_valid", req_D_valid_o, 0);
        chk("rst_mem_d_ready", mem_D_ready_o, 0);
        chk("rst_timeout", timeout_o, 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            req_A_valid_i = vt[i].valid;
            mem_A_ready_i = vt[i].rdy;
            @(negedge clk);
            chk("vec_mem_a_valid", mem_A_valid_o, vt[i].exp_mv);
            chk("vec_req_a_ready", req_A_ready_o, vt[i].exp_rdy);
            if (vt[i].exp_mv)
                chk("vec_source", mem_A_bits_o.source, pay(vt[i].exp_grant).source);
            @(posedge clk);
            #1;
            chk("vec_busy", busy_o, vt[i].exp_mv);
        end

        // single requester, then pointer must start at 2
        do_reset();
        mem_A_ready_i = 1'b1;
        left[1] = 1;
        apply_valid();
        wait_drain("s1_drain", 50);
        q = '{1};
        check_order("s1", q);
        grants.delete();
        for (int k = 0; k < N; k++) left[k] = 1;
        apply_valid();
        wait_drain("s1b_drain", 100);
        q = '{2, 0, 1};
        check_order("s1b", q);

        // all continuously valid with slower bridge
        do_reset();
        bridge_lat = 2;
        for (int k = 0; k < N; k++) left[k] = 2;
        apply_valid();
        wait_drain("s2_drain", 200);
        q = '{0, 1, 2, 0, 1, 2};
        check_order("s2", q);
        bridge_lat = 0;

        // downstream A stall; late requester 2 must not steal the hold
        do_reset();
        mem_A_ready_i = 1'b0;
        left[0] = 1;
        apply_valid();
        for (int c = 0; c < 5; c++) begin
            tick();
            if (c == 1) begin
                left[2] = 1;
                apply_valid();
            end
            #1;
            chk("s3_hold_source", mem_A_bits_o.source, pay(0).source);
            chk("s3_hold_busy", busy_o, 1);
            chk("s3_hold_ready", req_A_ready_o, 0);
        end
        mem_A_ready_i = 1'b1;
        wait_drain("s3_drain", 50);
        q = '{0, 2};
        check_order("s3", q);

        // upstream D backpressure
        do_reset();
        req_D_ready_i = 3'b101;
        left[1] = 1;
        apply_valid();
        n = 0;
        while (!mem_D_valid_i && n < 20) begin
            tick();
            n++;
        end
        chk("s4_d_arrives", mem_D_valid_i, 1);
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("s4_mem_d_ready", mem_D_ready_o, 0);
            chk("s4_req_d_valid", req_D_valid_o, 3'b010);
            chk("s4_d_data", req_D_bits_o[1].data, mem_data(pay(1).address));
            chk("s4_busy", busy_o, 1);
            tick();
        end
        req_D_ready_i = '1;
        wait_drain("s4_drain", 20);
        q = '{1};
        check_order("s4", q);

        // reset while waiting on D
        do_reset();
        left[0] = 1;
        apply_valid();
        wait_drain("s5a_drain", 50);
        bridge_on = 1'b0;
        left[1] = 1;
        apply_valid();
        n = 0;
        while (!(busy_o && outstanding != 0) && n < 20) begin
            tick();
            n++;
        end
        chk("s5_in_wait_d", busy_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        for (int k = 0; k < N; k++) left[k] = 0;
        apply_valid();
        sb.delete();
        grants.delete();
        outstanding = 0;
        pend = 1'b0;
        #1;
        chk("s5_busy", busy_o, 0);
        chk("s5_mem_a_valid", mem_A_valid_o, 0);
        chk("s5_req_d_valid", req_D_valid_o, 0);
        mem_D_bits_i  = '0;
        mem_D_valid_i = 1'b1;
        #1;
        chk("s5_stray_ready", mem_D_ready_o, 0);
        chk("s5_stray_valid", req_D_valid_o, 0);
        tick();
        mem_D_valid_i = 1'b0;
        bridge_on = 1'b1;
        for (int k = 0; k < N; k++) left[k] = 1;
        apply_valid();
        wait_drain("s5b_drain", 100);
        q = '{0, 1, 2};
        check_order("s5", q);
        chk("end_timeout", timeout_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
